// File: rtl/uart_rx_axis.sv
// uart_rx_axis
// UART receiver (8N1 framing, LSB first) driving an AXI-Stream master port.
// A 2-flop synchroniser brings the line into the clock domain. Each bit is
// sampled at its midpoint, and a start bit that does not last half a bit
// period is treated as a glitch. A single output register holds each byte
// until the downstream side accepts it.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   rx_in         serial input, asynchronous to clk, idle high
//   m_axis_ready  downstream ready
//   m_axis_valid  received byte available
//   m_axis_data   received byte (held stable while valid and not accepted)
//   frame_err     1-cycle pulse when the stop bit is sampled low
//   overrun       1-cycle pulse when a byte completes while the output is full;
//                 that new byte is dropped
//
// State table
//   IDLE  | waiting for a falling edge on the synchronised line
//   START | timing to the middle of the start bit to confirm it
//   DATA  | sampling WIDTH data bits, LSB first
//   STOP  | sampling the stop bit; deliver the byte or flag a framing error
//   BREAK | line held low after a framing error; wait for it to return high

module uart_rx_axis #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_in,
  input  logic             m_axis_ready,
  output logic             m_axis_valid,
  output logic [WIDTH-1:0] m_axis_data,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state;
  logic             sync_1;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] shift;

  // Both flops reset high so that reset does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx_in;
      rx_s   <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A completed byte in STOP below overrides this clear. That lets a new
      // byte load in the same cycle as a handshake.
      if (m_axis_valid && m_axis_ready) begin
        m_axis_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_M1) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!m_axis_valid || m_axis_ready) begin
                m_axis_valid <= 1'b1;
                m_axis_data  <= shift;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
